// File: rtl/pq_initiator.sv
// Buffered command client for a priority queue: FIFOs insert/remove commands and issues them one
// at a time over pq_if. Optional statistics counters are enabled with PQ_INIT_STATS_EN.
module pq_initiator #(
   parameter int unsigned KW        = 8,
   parameter int unsigned VW        = 8,
   parameter int unsigned CMD_DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic             cmd_op,
   input  logic [KW+VW-1:0] cmd_kv,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [KW+VW-1:0] res_kv,
   output logic             drop,
   output logic             idle,
   output logic             pq_insert,
   output logic             pq_remove,
   output logic [KW+VW-1:0] pq_kv_in,
   input  logic [KW+VW-1:0] pq_kv_out,
   input  logic             pq_busy,
   input  logic             pq_full,
   input  logic             pq_empty,
   output logic [15:0]      n_ins,
   output logic [15:0]      n_rem,
   output logic [15:0]      n_drop
);

   localparam int unsigned DW = KW + VW;
   localparam int unsigned AW = $clog2(CMD_DEPTH);
   localparam logic [AW:0] DEPTH_CNT = (AW+1)'(CMD_DEPTH);

   typedef enum logic [1:0] {StIdle, StWait, StHold} state_e;

   // FIFO entries carry {op, kv}
   logic [DW:0]   fifo_mem [CMD_DEPTH];
   logic [AW-1:0] rd_ptr_q, wr_ptr_q;
   logic [AW:0]   count_q;

   state_e        state_q;
   logic          wait_first_q;
   logic          op_rem_q;
   logic          res_valid_q;
   logic [DW-1:0] res_kv_q;

   logic          push, pop, fifo_empty, head_op, can_act;
   logic          do_ins, do_rem, do_drop;
   logic [DW-1:0] head_kv;

   assign fifo_empty = (count_q == '0);
   assign cmd_ready  = (count_q < DEPTH_CNT);
   assign push       = cmd_valid && cmd_ready;
   assign head_op    = fifo_mem[rd_ptr_q][DW];
   assign head_kv    = fifo_mem[rd_ptr_q][DW-1:0];

   // Status inputs only matter when the FSM is free to launch an operation
   assign can_act = (state_q == StIdle) && !fifo_empty && !pq_busy;
   assign do_drop = can_act && (head_op ? pq_empty : pq_full);
   assign do_ins  = can_act && !head_op && !pq_full;
   assign do_rem  = can_act && head_op && !pq_empty && !res_valid_q;
   assign pop     = do_drop || do_ins || do_rem;

   assign drop      = do_drop;
   assign pq_insert = do_ins;
   assign pq_remove = do_rem;
   assign pq_kv_in  = do_ins ? head_kv : '0;
   assign res_valid = res_valid_q;
   assign res_kv    = res_kv_q;
   assign idle      = fifo_empty && (state_q == StIdle) && !res_valid_q;

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem[wr_ptr_q] <= {cmd_op, cmd_kv};
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         count_q <= count_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= StIdle;
         wait_first_q <= 1'b0;
         op_rem_q     <= 1'b0;
         res_valid_q  <= 1'b0;
         res_kv_q     <= '0;
      end else begin
         if (res_valid_q && res_ready) res_valid_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (do_ins || do_rem) begin
                  state_q      <= StWait;
                  wait_first_q <= 1'b1;
                  op_rem_q     <= do_rem;
               end
            end
            StWait: begin
               // The PQ may not have raised busy yet in the first cycle
               wait_first_q <= 1'b0;
               if (!wait_first_q && !pq_busy) begin
                  if (op_rem_q) begin
                     res_kv_q    <= pq_kv_out;
                     res_valid_q <= 1'b1;
                     state_q     <= StHold;
                  end else begin
                     state_q <= StIdle;
                  end
               end
            end
            StHold:  state_q <= StIdle;
            default: state_q <= StIdle;
         endcase
      end
   end

`ifdef PQ_INIT_STATS_EN
   logic [15:0] n_ins_q, n_rem_q, n_drop_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         n_ins_q  <= '0;
         n_rem_q  <= '0;
         n_drop_q <= '0;
      end else begin
         if (do_ins && (n_ins_q != 16'hffff))   n_ins_q  <= n_ins_q + 16'd1;
         if (do_rem && (n_rem_q != 16'hffff))   n_rem_q  <= n_rem_q + 16'd1;
         if (do_drop && (n_drop_q != 16'hffff)) n_drop_q <= n_drop_q + 16'd1;
      end
   end

   assign n_ins  = n_ins_q;
   assign n_rem  = n_rem_q;
   assign n_drop = n_drop_q;
`else
   assign n_ins  = '0;
   assign n_rem  = '0;
   assign n_drop = '0;
`endif

endmodule

// File: tb/tb_pq_initiator.sv
// Directed bench for pq_initiator against a small min-first PQ model with adjustable busy time.
module tb_pq_initiator;

   localparam int DW = 16;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          cmd_valid = 1'b0, cmd_op = 1'b0, res_ready = 1'b1;
   logic [DW-1:0] cmd_kv = '0;
   logic          cmd_ready, res_valid, drop, idle, pq_insert, pq_remove;
   logic [DW-1:0] res_kv, pq_kv_in, pq_kv_out;
   logic          pq_busy, pq_full, pq_empty;
   logic [15:0]   n_ins, n_rem, n_drop;

   always #5 clk = ~clk;

   pq_initiator #(.KW(8), .VW(8), .CMD_DEPTH(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_kv(cmd_kv),
      .res_valid(res_valid), .res_ready(res_ready), .res_kv(res_kv),
      .drop(drop), .idle(idle), .pq_insert(pq_insert), .pq_remove(pq_remove),
      .pq_kv_in(pq_kv_in), .pq_kv_out(pq_kv_out),
      .pq_busy(pq_busy), .pq_full(pq_full), .pq_empty(pq_empty),
      .n_ins(n_ins), .n_rem(n_rem), .n_drop(n_drop)
   );

   // Min-first PQ model, capacity 8, busy for lat cycles after each pulse
   int            lat = 1;
   int            busy_cnt, pq_cnt, min_idx;
   logic [DW-1:0] pq_mem [0:7];

   assign pq_busy  = (busy_cnt != 0);
   assign pq_full  = (pq_cnt == 8);
   assign pq_empty = (pq_cnt == 0);

   always_comb begin
      min_idx = 0;
      for (int i = 1; i < 8; i++)
         if (i < pq_cnt && pq_mem[i][15:8] < pq_mem[min_idx][15:8]) min_idx = i;
   end

   always @(posedge clk) begin
      if (!rst_n) begin
         busy_cnt  <= 0;
         pq_cnt    <= 0;
         pq_kv_out <= '0;
      end else begin
         if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
         if (pq_insert) begin
            pq_mem[pq_cnt] <= pq_kv_in;
            pq_cnt         <= pq_cnt + 1;
            busy_cnt       <= lat;
         end else if (pq_remove && pq_cnt > 0) begin
            pq_kv_out       <= pq_mem[min_idx];
            pq_mem[min_idx] <= pq_mem[pq_cnt-1];
            pq_cnt          <= pq_cnt - 1;
            busy_cnt        <= lat;
         end
      end
   end

   // Pulse / result monitor
   int            cyc = 0, ins_cnt = 0, rem_cnt = 0, drop_cnt = 0, viol_cnt = 0;
   int            last_ins_cyc = 0, ins_gap = 0, res_cnt = 0;
   logic [DW-1:0] res_arr [0:31];

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (rst_n) begin
         if (pq_insert) begin
            ins_cnt      <= ins_cnt + 1;
            ins_gap      <= cyc - last_ins_cyc;
            last_ins_cyc <= cyc;
         end
         if (pq_remove) rem_cnt <= rem_cnt + 1;
         if (drop) drop_cnt <= drop_cnt + 1;
         if ((pq_insert || pq_remove) && pq_busy) viol_cnt <= viol_cnt + 1;
         if (res_valid && res_ready) begin
            res_arr[res_cnt] <= res_kv;
            res_cnt          <= res_cnt + 1;
         end
      end
   end

   int n_chk = 0, n_pass = 0, n_fail = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // Called at posedge+1; returns at posedge+1 of the cycle after acceptance
   task automatic push(input logic op, input logic [DW-1:0] kv);
      int n = 0;
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_kv    = kv;
      while (!cmd_ready && n < 300) begin
         @(posedge clk); #1;
         n++;
      end
      if (!cmd_ready) check("push_ready_timeout", 32'(cmd_ready), 32'd1);
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      cmd_op    = 1'b0;
      cmd_kv    = '0;
   endtask

   task automatic wait_idle(input string tag);
      int n = 0;
      while (!idle && n < 300) begin
         @(posedge clk); #1;
         n++;
      end
      check(tag, 32'(idle), 32'd1);
   endtask

   task automatic check_stats(input string tag, input int ei, input int er, input int ed);
`ifdef PQ_INIT_STATS_EN
      check({tag, "_n_ins"}, 32'(n_ins), 32'(ei));
      check({tag, "_n_rem"}, 32'(n_rem), 32'(er));
      check({tag, "_n_drop"}, 32'(n_drop), 32'(ed));
`else
      check({tag, "_n_ins"}, 32'(n_ins), 32'd0 & 32'(ei));
      check({tag, "_n_rem"}, 32'(n_rem), 32'd0 & 32'(er));
      check({tag, "_n_drop"}, 32'(n_drop), 32'd0 & 32'(ed));
`endif
   endtask

   initial begin
      int ins0, rem0;
      // Reset: three cycles low
      repeat (3) @(posedge clk);
      #1;
      check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
      check("rst_idle", 32'(idle), 32'd1);
      check("rst_res_valid", 32'(res_valid), 32'd0);
      check("rst_res_kv", 32'(res_kv), 32'd0);
      check("rst_drop", 32'(drop), 32'd0);
      check("rst_pq_insert", 32'(pq_insert), 32'd0);
      check("rst_pq_remove", 32'(pq_remove), 32'd0);
      check("rst_pq_kv_in", 32'(pq_kv_in), 32'd0);
      check_stats("rst", 0, 0, 0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Inserts 5, 3, 9: first pulse one cycle after acceptance
      push(1'b0, 16'h0555);
      check("ins_first_pulse", 32'(pq_insert), 32'd1);
      check("ins_first_kv", 32'(pq_kv_in), 32'h0555);
      push(1'b0, 16'h0333);
      push(1'b0, 16'h0999);
      wait_idle("ins3_idle");
      check("ins3_count", 32'(ins_cnt), 32'd3);
      check("ins_gap_lat1", 32'(ins_gap), 32'd3);

      // First remove: pulse at t+1, result valid at t+4
      push(1'b1, 16'h0000);
      check("rem_first_pulse", 32'(pq_remove), 32'd1);
      repeat (3) @(posedge clk);
      #1;
      check("rem_first_valid", 32'(res_valid), 32'd1);
      check("rem_first_kv", 32'(res_kv), 32'h0333);
      push(1'b1, 16'h0000);
      push(1'b1, 16'h0000);
      wait_idle("rem3_idle");
      check("rem3_res0", 32'(res_arr[0]), 32'h0333);
      check("rem3_res1", 32'(res_arr[1]), 32'h0555);
      check("rem3_res2", 32'(res_arr[2]), 32'h0999);
      check_stats("heap", 3, 3, 0);

      // Remove to an empty PQ drops; the queued insert issues right after
      push(1'b1, 16'h0000);
      check("drop_pulse", 32'(drop), 32'd1);
      check("drop_no_remove", 32'(pq_remove), 32'd0);
      push(1'b0, 16'h0777);
      check("after_drop_insert", 32'(pq_insert), 32'd1);
      check("after_drop_kv", 32'(pq_kv_in), 32'h0777);
      check("after_drop_no_drop", 32'(drop), 32'd0);
      wait_idle("drop_idle");
      check("drop_count", 32'(drop_cnt), 32'd1);
      check("drop_rem_count", 32'(rem_cnt), 32'd3);
      check_stats("drop", 4, 3, 1);
      push(1'b1, 16'h0000);
      wait_idle("rem7_idle");
      check("rem7_res", 32'(res_arr[3]), 32'h0777);

      // Slow PQ: busy held 4 cycles per operation
      lat = 4;
      ins0 = ins_cnt;
      push(1'b0, 16'h0111);
      push(1'b0, 16'h0222);
      wait_idle("slow_idle");
      check("slow_ins_pulses", 32'(ins_cnt - ins0), 32'd2);
      check("slow_ins_gap", 32'(ins_gap), 32'd6);
      check("slow_no_busy_pulse", 32'(viol_cnt), 32'd0);
      lat = 1;
      push(1'b1, 16'h0000);
      push(1'b1, 16'h0000);
      wait_idle("slow_rem_idle");
      check("slow_res0", 32'(res_arr[4]), 32'h0111);
      check("slow_res1", 32'(res_arr[5]), 32'h0222);

      // Result back-pressure stalls the next remove and fills the FIFO
      push(1'b0, 16'h0444);
      push(1'b0, 16'h0555);
      wait_idle("bp_fill_idle");
      res_ready = 1'b0;
      rem0 = rem_cnt;
      push(1'b1, 16'h0000);
      repeat (4) @(posedge clk);
      #1;
      check("bp_res_valid", 32'(res_valid), 32'd1);
      check("bp_res_kv", 32'(res_kv), 32'h0444);
      push(1'b1, 16'h0000);
      push(1'b0, 16'h0a01);
      push(1'b0, 16'h0b02);
      push(1'b0, 16'h0c03);
      check("bp_cmd_ready_low", 32'(cmd_ready), 32'd0);
      repeat (3) @(posedge clk);
      #1;
      check("bp_no_second_remove", 32'(rem_cnt - rem0), 32'd1);
      check("bp_still_full", 32'(cmd_ready), 32'd0);
      check("bp_res_held", 32'(res_kv), 32'h0444);
      res_ready = 1'b1;
      push(1'b0, 16'h0d04);
      wait_idle("bp_drain_idle");
      check("bp_res0", 32'(res_arr[6]), 32'h0444);
      check("bp_res1", 32'(res_arr[7]), 32'h0555);
      check("bp_res_count", 32'(res_cnt), 32'd8);
      check("bp_ins_total", 32'(ins_cnt), 32'd12);
      check_stats("bp", 12, 8, 1);

      // Reset in the middle of WAIT
      lat = 4;
      rem0 = rem_cnt;
      push(1'b1, 16'h0000);
      check("rstw_remove_pulse", 32'(pq_remove), 32'd1);
      push(1'b0, 16'h0e05);
      rst_n = 1'b0;
      @(posedge clk); #1;
      check("rstw_idle", 32'(idle), 32'd1);
      check("rstw_cmd_ready", 32'(cmd_ready), 32'd1);
      check("rstw_res_valid", 32'(res_valid), 32'd0);
      check("rstw_res_kv", 32'(res_kv), 32'd0);
      check("rstw_pq_insert", 32'(pq_insert), 32'd0);
      check_stats("rstw", 0, 0, 0);
      rst_n = 1'b1;
      ins0 = ins_cnt;
      repeat (10) @(posedge clk);
      #1;
      check("rstw_no_insert", 32'(ins_cnt - ins0), 32'd0);
      check("rstw_no_remove", 32'(rem_cnt - rem0), 32'd1);
      check("rstw_idle_after", 32'(idle), 32'd1);
      check("final_no_busy_pulse", 32'(viol_cnt), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: observed running, expected finished");
      $fatal(1, "simulation time limit reached");
   end

endmodule
